// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl
// Purpose  : Wide add/subtract sequenced through one 4-bit adder slice,
//            one nibble per clock, least-significant nibble first.
// Revision : 1.0  initial release
// ============================================================================
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   A,
  input  logic [4*NIBBLES-1:0]   B,
  input  logic                   Cin,
  input  logic                   SUB,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   Z,
  output logic                   Cout,
  output logic                   OVF
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_acc;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_z;
  logic            r_cout;
  logic            r_ovf;

  logic            w_accept;
  logic            w_last;
  logic [4:0]      w_slice;
  logic [3:0]      w_sum;
  logic            w_cout;
  logic [W-1:0]    w_acc_next;

  // The single shared 4-bit slice: low nibbles plus the held carry.
  assign w_slice = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0000, r_carry};
  assign w_sum   = w_slice[3:0];
  assign w_cout  = w_slice[4];

  generate
    if (NIBBLES == 1) begin : g_one_nibble
      assign w_acc_next = w_sum;
    end else begin : g_multi_nibble
      assign w_acc_next = {w_sum, r_acc[W-1:4]};
    end
  endgenerate

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_RUN) && (r_cnt == C_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: invert B and force the carry at capture time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_z     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= SUB ? ~B : B;
      r_carry <= SUB ? 1'b1 : Cin;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> 4;
      r_b     <= r_b >> 4;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CW'(1);
      r_acc   <= w_acc_next;
      if (w_last) begin
        r_z    <= w_acc_next;
        r_cout <= w_cout;
        r_ovf  <= (r_a[3] == r_b[3]) && (w_sum[3] != r_a[3]);
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign Z    = r_z;
  assign Cout = r_cout;
  assign OVF  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder_ctrl
// Purpose  : Randomized self-checking bench against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0, sub = 1'b0;
  logic        busy, done, cout, ovf;
  logic [15:0] z;

  logic        s1_start = 1'b0;
  logic [3:0]  s1_a = '0, s1_b = '0;
  logic        s1_cin = 1'b0, s1_sub = 1'b0;
  logic        s1_busy, s1_done, s1_cout, s1_ovf;
  logic [3:0]  s1_z;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .Cin(cin), .SUB(sub),
    .busy(busy), .done(done), .Z(z), .Cout(cout), .OVF(ovf)
  );

  nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(s1_start), .A(s1_a), .B(s1_b), .Cin(s1_cin), .SUB(s1_sub),
    .busy(s1_busy), .done(s1_done), .Z(s1_z), .Cout(s1_cout), .OVF(s1_ovf)
  );

  // Reference: {ovf, cout, z} of an nb-nibble add/subtract, by plain arithmetic.
  function automatic logic [17:0] model(input int nb, input logic [15:0] ta, input logic [15:0] tb,
                                        input logic tcin, input logic tsub);
    int w;
    logic [16:0] mask, aa, bb, s;
    logic c, ov;
    w    = 4 * nb;
    mask = (17'd1 << w) - 17'd1;
    aa   = {1'b0, ta} & mask;
    bb   = tsub ? (~{1'b0, tb} & mask) : ({1'b0, tb} & mask);
    s    = aa + bb + (tsub ? 17'd1 : {16'd0, tcin});
    c    = s[w];
    ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {ov, c, s[15:0] & mask[15:0]};
  endfunction

  task automatic run4(input logic [15:0] ta, input logic [15:0] tb, input logic tcin, input logic tsub);
    logic [17:0] e;
    e = model(4, ta, tb, tcin, tsub);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb; cin = tcin; sub = tsub;
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL run_busy k=%0d busy=%b done=%b required busy=1 done=0", k, busy, done);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL run_done busy=%b done=%b required busy=0 done=1", busy, done);
    end
    checks++;
    if (z !== e[15:0] || cout !== e[16] || ovf !== e[17]) begin
      errors++;
      $display("FAIL run_result A=%h B=%h Cin=%b SUB=%b got Z=%h Cout=%b OVF=%b required Z=%h Cout=%b OVF=%b",
               ta, tb, tcin, tsub, z, cout, ovf, e[15:0], e[16], e[17]);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || z !== e[15:0]) begin
      errors++;
      $display("FAIL run_hold done=%b Z=%h required done=0 Z=%h", done, z, e[15:0]);
    end
  endtask

  task automatic run1(input logic [3:0] ta, input logic [3:0] tb, input logic tcin, input logic tsub);
    logic [17:0] e;
    e = model(1, {12'd0, ta}, {12'd0, tb}, tcin, tsub);
    @(negedge clk);
    s1_start = 1'b1; s1_a = ta; s1_b = tb; s1_cin = tcin; s1_sub = tsub;
    @(negedge clk);
    s1_start = 1'b0; s1_a = 4'($urandom); s1_b = 4'($urandom);
    checks++;
    if (s1_busy !== 1'b1 || s1_done !== 1'b0) begin
      errors++;
      $display("FAIL n1_busy busy=%b done=%b required busy=1 done=0", s1_busy, s1_done);
    end
    @(negedge clk);
    checks++;
    if (s1_done !== 1'b1 || s1_z !== e[3:0] || s1_cout !== e[16] || s1_ovf !== e[17]) begin
      errors++;
      $display("FAIL n1_result A=%h B=%h SUB=%b got done=%b Z=%h Cout=%b OVF=%b required done=1 Z=%h Cout=%b OVF=%b",
               ta, tb, tsub, s1_done, s1_z, s1_cout, s1_ovf, e[3:0], e[16], e[17]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || z !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b Z=%h Cout=%b OVF=%b required all zero", busy, done, z, cout, ovf);
    end
    checks++;
    if (s1_busy !== 1'b0 || s1_done !== 1'b0 || s1_z !== 4'h0 || s1_cout !== 1'b0 || s1_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state_n1 busy=%b done=%b Z=%h required all zero", s1_busy, s1_done, s1_z);
    end
    rst = 1'b0;
  endtask

  task automatic test_add_basic;
    run4(16'h1234, 16'h0FCC, 1'b0, 1'b0);
    run4(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run4(16'h7FFF, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_sub_basic;
    run4(16'h0005, 16'h0007, 1'b1, 1'b1);
    run4(16'h8000, 16'h0001, 1'b0, 1'b1);
    run4(16'h1234, 16'h1234, 1'b0, 1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++)
      run4(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic test_back_to_back;
    logic [15:0] a1, b1, a2, b2;
    logic c1, c2, u1, u2;
    logic [17:0] e1, e2;
    a1 = 16'($urandom); b1 = 16'($urandom); c1 = 1'($urandom); u1 = 1'($urandom);
    a2 = 16'($urandom); b2 = 16'($urandom); c2 = 1'($urandom); u2 = 1'($urandom);
    e1 = model(4, a1, b1, c1, u1);
    e2 = model(4, a2, b2, c2, u2);
    @(negedge clk);
    start = 1'b1; a = a1; b = b1; cin = c1; sub = u1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_busy1 k=%0d busy=%b done=%b required busy=1 done=0", k, busy, done);
      end
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || z !== e1[15:0] || cout !== e1[16] || ovf !== e1[17]) begin
      errors++;
      $display("FAIL b2b_first done=%b Z=%h Cout=%b OVF=%b required done=1 Z=%h Cout=%b OVF=%b",
               done, z, cout, ovf, e1[15:0], e1[16], e1[17]);
    end
    a = a2; b = b2; cin = c2; sub = u2;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_relaunch busy=%b done=%b required busy=1 done=0", busy, done);
    end
    start = 1'b0; a = 16'($urandom); b = 16'($urandom);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_busy2 k=%0d busy=%b done=%b required busy=1 done=0", k, busy, done);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || z !== e2[15:0] || cout !== e2[16] || ovf !== e2[17]) begin
      errors++;
      $display("FAIL b2b_second done=%b Z=%h Cout=%b OVF=%b required done=1 Z=%h Cout=%b OVF=%b",
               done, z, cout, ovf, e2[15:0], e2[16], e2[17]);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle busy=%b done=%b required both 0", busy, done);
    end
  endtask

  task automatic test_async_reset;
    run4(16'h7FFF, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b1; a = 16'h4321; b = 16'h1111; cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || z !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL async_reset busy=%b done=%b Z=%h Cout=%b OVF=%b required all zero", busy, done, z, cout, ovf);
    end
    #2 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abandoned_op k=%0d busy=%b done=%b required both 0", k, busy, done);
      end
    end
    run4(16'h4321, 16'h1111, 1'b0, 1'b0);
  endtask

  task automatic test_single_nibble;
    run1(4'hC, 4'hB, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      run1(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_sub_basic();
    test_random();
    test_back_to_back();
    test_async_reset();
    test_single_nibble();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
